// File: rtl/mmio_ctrl.sv
// Memory-mapped output controller: CH channel registers plus a STATUS word.
// Optional registered readback is enabled by defining MMIO_CTRL_READBACK_EN.
module mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h20,
  parameter int unsigned CH        = 4,
  parameter int unsigned DW        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      data,
  input  logic             we,
  input  logic             re,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic [CH*DW-1:0] data_out,
  output logic [CH-1:0]    upd,
  output logic             err,
  output logic [15:0]      wr_cnt
);

  localparam int unsigned IW       = $clog2(CH + 1);
  localparam logic [31:0] WIN_HI   = BASE_ADDR + 32'(4 * CH + 3);
  localparam logic [IW-1:0] ST_IDX = IW'(CH);

  logic [DW-1:0] ch_q [CH];
  logic [DW-1:0] ch_d [CH];
  logic [CH-1:0] upd_q, upd_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          in_win, aligned, is_stat;
  logic [31:0]   off;
  logic [IW-1:0] widx;
  logic          wr_ch, wr_st, wr_bad, rd_bad;

  // Address decode: word index inside the window, STATUS is the last word
  assign in_win  = (addr >= BASE_ADDR) && (addr <= WIN_HI);
  assign aligned = (addr[1:0] == 2'b00);
  assign off     = addr - BASE_ADDR;
  assign widx    = off[IW+1:2];
  assign is_stat = (widx == ST_IDX);
  assign wr_ch   = we && in_win && aligned && !is_stat;
  assign wr_st   = we && in_win && aligned && is_stat;
  assign wr_bad  = we && in_win && !aligned;

  // Next-state for channel, strobe, counter and error registers
  always_comb begin
    ch_d  = ch_q;
    upd_d = '0;
    cnt_d = cnt_q;
    err_d = err_q;
    for (int i = 0; i < int'(CH); i++) begin
      if (wr_ch && (widx == IW'(i))) begin
        ch_d[i]  = data[DW-1:0];
        upd_d[i] = 1'b1;
      end
    end
    if (wr_ch) cnt_d = cnt_q + 16'd1;
    if (wr_st && data[31]) err_d = 1'b0;
    // A fault in the same cycle as a clear leaves the flag set
    if (wr_bad || rd_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CH); i++) ch_q[i] <= '0;
      upd_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ch_q  <= ch_d;
      upd_q <= upd_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < int'(CH); i++) data_out[i*DW +: DW] = ch_q[i];
  end

  assign upd    = upd_q;
  assign err    = err_q;
  assign wr_cnt = cnt_q;

`ifdef MMIO_CTRL_READBACK_EN
  logic        rd_ok;
  logic [31:0] rd_val;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  assign rd_ok  = re && in_win && aligned;
  assign rd_bad = re && in_win && !aligned;

  // Read mux samples pre-write register contents
  always_comb begin
    rd_val = {err_q, 15'b0, cnt_q};
    for (int i = 0; i < int'(CH); i++) begin
      if (widx == IW'(i)) rd_val = 32'(ch_q[i]);
    end
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (rd_ok) begin
      rdata_d  = rd_val;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`else
  assign rd_bad = 1'b0;
  assign rdata  = '0;
  assign rvalid = 1'b0;
`endif

  // Address/data bits that feed no logic in a given configuration
  logic unused_ok;
  assign unused_ok = ^{re, data, off};

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed self-checking bench for mmio_ctrl (default parameters).
// Expectations adapt to MMIO_CTRL_READBACK_EN when it is defined.
module tb_mmio_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] data;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        rvalid;
  logic [63:0] data_out;
  logic [3:0]  upd;
  logic        err;
  logic [15:0] wr_cnt;

  int pass_cnt = 0;
  int total    = 0;

  mmio_ctrl #(.BASE_ADDR(32'h20), .CH(4), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data(data), .we(we), .re(re),
    .rdata(rdata), .rvalid(rvalid), .data_out(data_out), .upd(upd),
    .err(err), .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MMIO_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; addr = '0; data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    total++; if (data_out !== 64'h0) $display("FAIL reset data_out got %h exp 0", data_out); else pass_cnt++;
    total++; if (upd !== 4'h0) $display("FAIL reset upd got %b exp 0", upd); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL reset err got %b exp 0", err); else pass_cnt++;
    total++; if (wr_cnt !== 16'h0) $display("FAIL reset wr_cnt got %h exp 0", wr_cnt); else pass_cnt++;
    total++; if (rdata !== 32'h0) $display("FAIL reset rdata got %h exp 0", rdata); else pass_cnt++;
    total++; if (rvalid !== 1'b0) $display("FAIL reset rvalid got %b exp 0", rvalid); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    we = 1'b1; addr = 32'h24; data = 32'hABCD1234;
    tick();
    idle();
    total++; if (data_out !== 64'h00000000_12340000) $display("FAIL write data_out got %h exp 0000000012340000", data_out); else pass_cnt++;
    total++; if (upd !== 4'b0010) $display("FAIL write upd got %b exp 0010", upd); else pass_cnt++;
    total++; if (wr_cnt !== 16'd1) $display("FAIL write wr_cnt got %0d exp 1", wr_cnt); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL write err got %b exp 0", err); else pass_cnt++;
    tick();
    total++; if (upd !== 4'b0000) $display("FAIL write upd_drop got %b exp 0000", upd); else pass_cnt++;
    total++; if (data_out !== 64'h00000000_12340000) $display("FAIL write hold got %h exp 0000000012340000", data_out); else pass_cnt++;
  endtask

  task automatic test_outside();
    we = 1'b1; addr = 32'h100; data = 32'hFFFFFFFF;
    tick();
    addr = 32'h1C; re = 1'b1;
    total++; if (upd !== 4'b0000) $display("FAIL out_hi upd got %b exp 0000", upd); else pass_cnt++;
    total++; if (data_out !== 64'h00000000_12340000) $display("FAIL out_hi data_out got %h", data_out); else pass_cnt++;
    tick();
    idle();
    total++; if (wr_cnt !== 16'd1) $display("FAIL out_lo wr_cnt got %0d exp 1", wr_cnt); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL out_lo err got %b exp 0", err); else pass_cnt++;
    total++; if (rvalid !== 1'b0) $display("FAIL out_lo rvalid got %b exp 0", rvalid); else pass_cnt++;
    total++; if (data_out !== 64'h00000000_12340000) $display("FAIL out_lo data_out got %h", data_out); else pass_cnt++;
  endtask

  task automatic test_err();
    we = 1'b1; addr = 32'h22; data = 32'h00005555;
    tick();
    total++; if (err !== 1'b1) $display("FAIL misalign err got %b exp 1", err); else pass_cnt++;
    total++; if (wr_cnt !== 16'd1) $display("FAIL misalign wr_cnt got %0d exp 1", wr_cnt); else pass_cnt++;
    total++; if (upd !== 4'b0000) $display("FAIL misalign upd got %b exp 0000", upd); else pass_cnt++;
    total++; if (data_out !== 64'h00000000_12340000) $display("FAIL misalign data_out got %h", data_out); else pass_cnt++;
    addr = 32'h30; data = 32'h7FFFFFFF;
    tick();
    total++; if (err !== 1'b1) $display("FAIL noclear err got %b exp 1", err); else pass_cnt++;
    data = 32'h80000000;
    tick();
    total++; if (err !== 1'b0) $display("FAIL clear err got %b exp 0", err); else pass_cnt++;
    total++; if (wr_cnt !== 16'd1) $display("FAIL clear wr_cnt got %0d exp 1", wr_cnt); else pass_cnt++;
    total++; if (upd !== 4'b0000) $display("FAIL clear upd got %b exp 0000", upd); else pass_cnt++;
    addr = 32'h33; data = 32'h0;
    tick();
    total++; if (err !== 1'b1) $display("FAIL win_end err got %b exp 1", err); else pass_cnt++;
    addr = 32'h30; data = 32'h80000000;
    tick();
    idle();
    total++; if (err !== 1'b0) $display("FAIL reclear err got %b exp 0", err); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    we = 1'b1; addr = 32'h20; data = 32'h5555AAAA;
    tick();
    total++; if (upd !== 4'b0001) $display("FAIL b2b_1 upd got %b exp 0001", upd); else pass_cnt++;
    total++; if (data_out[15:0] !== 16'hAAAA) $display("FAIL b2b_1 ch0 got %h exp AAAA", data_out[15:0]); else pass_cnt++;
    data = 32'h00001111;
    tick();
    idle();
    total++; if (upd !== 4'b0001) $display("FAIL b2b_2 upd got %b exp 0001", upd); else pass_cnt++;
    total++; if (data_out !== 64'h00000000_12341111) $display("FAIL b2b_2 data_out got %h", data_out); else pass_cnt++;
    total++; if (wr_cnt !== 16'd3) $display("FAIL b2b_2 wr_cnt got %0d exp 3", wr_cnt); else pass_cnt++;
    tick();
    total++; if (upd !== 4'b0000) $display("FAIL b2b_end upd got %b exp 0000", upd); else pass_cnt++;
  endtask

  task automatic test_readback();
    logic [31:0] e_rd;
    we = 1'b1; addr = 32'h2C; data = 32'h000000FF;
    tick();
    total++; if (data_out !== 64'h00FF0000_12341111) $display("FAIL rb_wr data_out got %h", data_out); else pass_cnt++;
    we = 1'b0; re = 1'b1;
    tick();
    re = 1'b0;
    e_rd = RB ? 32'h000000FF : 32'h0;
    total++; if (rdata !== e_rd) $display("FAIL rd_ch3 rdata got %h exp %h", rdata, e_rd); else pass_cnt++;
    total++; if (rvalid !== RB) $display("FAIL rd_ch3 rvalid got %b exp %b", rvalid, RB); else pass_cnt++;
    tick();
    total++; if (rvalid !== 1'b0) $display("FAIL rd_pulse rvalid got %b exp 0", rvalid); else pass_cnt++;
    total++; if (rdata !== e_rd) $display("FAIL rd_hold rdata got %h exp %h", rdata, e_rd); else pass_cnt++;
    re = 1'b1; addr = 32'h30;
    tick();
    e_rd = RB ? 32'h00000004 : 32'h0;
    total++; if (rdata !== e_rd) $display("FAIL rd_stat rdata got %h exp %h", rdata, e_rd); else pass_cnt++;
    addr = 32'h2D;
    tick();
    re = 1'b0;
    total++; if (err !== RB) $display("FAIL rd_mis err got %b exp %b", err, RB); else pass_cnt++;
    total++; if (rvalid !== 1'b0) $display("FAIL rd_mis rvalid got %b exp 0", rvalid); else pass_cnt++;
    total++; if (rdata !== e_rd) $display("FAIL rd_mis rdata got %h exp %h", rdata, e_rd); else pass_cnt++;
    we = 1'b1; addr = 32'h30; data = 32'h80000000;
    tick();
    we = 1'b1; re = 1'b1; addr = 32'h24; data = 32'h00009999;
    tick();
    idle();
    e_rd = RB ? 32'h00001234 : 32'h0;
    total++; if (rdata !== e_rd) $display("FAIL rw_same rdata got %h exp %h", rdata, e_rd); else pass_cnt++;
    total++; if (data_out[31:16] !== 16'h9999) $display("FAIL rw_same ch1 got %h exp 9999", data_out[31:16]); else pass_cnt++;
    total++; if (wr_cnt !== 16'd5) $display("FAIL rw_same wr_cnt got %0d exp 5", wr_cnt); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL rw_same err got %b exp 0", err); else pass_cnt++;
    tick();
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    total++; if (wr_cnt !== 16'd0) $display("FAIL wrap_rst wr_cnt got %0d exp 0", wr_cnt); else pass_cnt++;
    we = 1'b1; addr = 32'h20;
    for (int i = 0; i < 65536; i++) begin
      data = 32'(i);
      tick();
    end
    total++; if (wr_cnt !== 16'd0) $display("FAIL wrap wr_cnt got %0d exp 0", wr_cnt); else pass_cnt++;
    total++; if (data_out[15:0] !== 16'hFFFF) $display("FAIL wrap ch0 got %h exp FFFF", data_out[15:0]); else pass_cnt++;
    data = 32'h00000042;
    tick();
    idle();
    total++; if (wr_cnt !== 16'd1) $display("FAIL wrap_p1 wr_cnt got %0d exp 1", wr_cnt); else pass_cnt++;
    total++; if (upd !== 4'b0001) $display("FAIL wrap_p1 upd got %b exp 0001", upd); else pass_cnt++;
    tick();
  endtask

  task automatic test_async_reset();
    we = 1'b1; addr = 32'h20; data = 32'h0000BEEF;
    tick();
    idle();
    total++; if (upd !== 4'b0001) $display("FAIL arst_pre upd got %b exp 0001", upd); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (upd !== 4'b0000) $display("FAIL arst upd got %b exp 0000", upd); else pass_cnt++;
    total++; if (data_out !== 64'h0) $display("FAIL arst data_out got %h exp 0", data_out); else pass_cnt++;
    total++; if (wr_cnt !== 16'd0) $display("FAIL arst wr_cnt got %0d exp 0", wr_cnt); else pass_cnt++;
    we = 1'b1; addr = 32'h24; data = 32'h00001234;
    tick();
    idle();
    total++; if (data_out !== 64'h0) $display("FAIL arst_held data_out got %h exp 0", data_out); else pass_cnt++;
    total++; if (wr_cnt !== 16'd0) $display("FAIL arst_held wr_cnt got %0d exp 0", wr_cnt); else pass_cnt++;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_outside();
    test_err();
    test_back_to_back();
    test_readback();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
